vrased_monitor: RTL and testbench

//  Parametrised successor to the VRASED top-level checker. One block replaces the fixed per-property
//  sub-monitors and checks three things: atomic SMEM entry/exit, DMA during attestation, and
//  N_REG configurable protected regions.

---
 rtl/vrased_monitor_pkg.sv | 32 +++
 rtl/vrased_region_chk.sv | 35 +++
 rtl/vrased_monitor.sv | 108 ++++++++++
 tb/tb_vrased_monitor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vrased_monitor_pkg.sv
// Shared types for the VRASED monitor: region modes, FSM states, cause bit indices
// and the overflow-safe address range test.
package vrased_monitor_pkg;

    typedef enum logic [1:0] {
        MODE_KEY    = 2'd0,
        MODE_XSTACK = 2'd1,
        MODE_WPROT  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_e;

    localparam int CAUSE_ENTRY = 0;
    localparam int CAUSE_EXIT  = 1;
    localparam int CAUSE_IRQ   = 2;
    localparam int CAUSE_DMA   = 3;
    localparam int CAUSE_REG0  = 4;

    // The end is formed in 17 bits so a range ending exactly at 64K does not wrap to 0.
    function automatic logic addr_hit(input logic [15:0] a,
                                      input logic [15:0] base,
                                      input logic [15:0] size);
        logic [16:0] w_end;
        w_end = {1'b0, base} + {1'b0, size};
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < w_end);
    endfunction

endpackage

// File: rtl/vrased_region_chk.sv
// One protected-region check, purely combinational; no flow control.
// CPU accesses only flag while executing outside SMEM, DMA hits always flag.
module vrased_region_chk
    import vrased_monitor_pkg::*;
(
    input  logic [15:0] i_base,
    input  logic [15:0] i_size,
    input  mode_e       i_mode,
    input  logic        i_data_en,
    input  logic        i_data_wr,
    input  logic [15:0] i_data_addr,
    input  logic        i_dma_en,
    input  logic [15:0] i_dma_addr,
    input  logic        i_in_smem,
    output logic        o_viol
);

    logic w_cpu_hit;
    logic w_dma_hit;

    assign w_cpu_hit = addr_hit(i_data_addr, i_base, i_size) & ~i_in_smem;
    assign w_dma_hit = i_dma_en & addr_hit(i_dma_addr, i_base, i_size);

    always_comb begin
        o_viol = 1'b0;
        case (i_mode)
            MODE_KEY,
            MODE_XSTACK: o_viol = (i_data_en & w_cpu_hit) | w_dma_hit;
            MODE_WPROT:  o_viol = (i_data_en & i_data_wr & w_cpu_hit) | w_dma_hit;
            MODE_OFF:    o_viol = 1'b0;
            default:     o_viol = 1'b0;
        endcase
    end

endmodule

// File: rtl/vrased_monitor.sv
// VRASED checker: SMEM atomicity, DMA/IRQ during attestation and N_REG regions drive a
// registered core reset one cycle after a violation; reset holds >= HOLD_CYCLES, no backpressure.
module vrased_monitor
    import vrased_monitor_pkg::*;
#(
    parameter logic [15:0]          SMEM_BASE     = 16'hA000,
    parameter logic [15:0]          SMEM_SIZE     = 16'h4000,
    parameter int unsigned          N_REG         = 3,
    parameter logic [16*N_REG-1:0]  REG_BASE      = {16'h6A00, 16'h0400, 16'h0230},
    parameter logic [16*N_REG-1:0]  REG_SIZE      = {16'h001F, 16'h0C00, 16'h0020},
    parameter logic [2*N_REG-1:0]   REG_MODE      = {2'd0, 2'd1, 2'd2},
    parameter logic [15:0]          RESET_HANDLER = 16'h0000,
    parameter int unsigned          HOLD_CYCLES   = 4,
    parameter int unsigned          CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         i_pc,
    input  logic                i_data_en,
    input  logic                i_data_wr,
    input  logic [15:0]         i_data_addr,
    input  logic                i_dma_en,
    input  logic [15:0]         i_dma_addr,
    input  logic                i_irq,
    output logic                o_reset,
    output logic [N_REG+3:0]    o_viol_cause,
    output logic [CNT_W-1:0]    o_viol_cnt
);

    localparam logic [15:0]       SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;
    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e             r_state;
    logic [15:0]        r_prev_pc;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_reset;
    logic [N_REG+3:0]   r_cause;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_pc_in;
    logic               w_prev_in;
    logic [N_REG+3:0]   w_viol;

    assign w_pc_in   = addr_hit(i_pc, SMEM_BASE, SMEM_SIZE);
    assign w_prev_in = addr_hit(r_prev_pc, SMEM_BASE, SMEM_SIZE);

    assign w_viol[CAUSE_ENTRY] = ~w_prev_in & w_pc_in & (i_pc != SMEM_BASE);
    assign w_viol[CAUSE_EXIT]  = w_prev_in & ~w_pc_in & (r_prev_pc != SMEM_LAST);
    assign w_viol[CAUSE_IRQ]   = i_irq & w_pc_in;
    assign w_viol[CAUSE_DMA]   = i_dma_en & w_pc_in;

    for (genvar g = 0; g < N_REG; g++) begin : g_region
        vrased_region_chk u_region_chk (
            .i_base      (REG_BASE[16*g +: 16]),
            .i_size      (REG_SIZE[16*g +: 16]),
            .i_mode      (mode_e'(REG_MODE[2*g +: 2])),
            .i_data_en   (i_data_en),
            .i_data_wr   (i_data_wr),
            .i_data_addr (i_data_addr),
            .i_dma_en    (i_dma_en),
            .i_dma_addr  (i_dma_addr),
            .i_in_smem   (w_pc_in),
            .o_viol      (w_viol[CAUSE_REG0 + g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_KILL;
            r_prev_pc  <= RESET_HANDLER;
            r_hold_cnt <= '0;
            r_reset    <= 1'b1;
            r_cause    <= '0;
            r_cnt      <= '0;
        end else begin
            r_prev_pc <= i_pc;
            case (r_state)
                ST_RUN: begin
                    if (|w_viol) begin
                        r_state    <= ST_KILL;
                        r_reset    <= 1'b1;
                        r_cause    <= w_viol;
                        r_hold_cnt <= '0;
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    // Violations seen while already held in reset are deliberately dropped.
                    if ((r_hold_cnt == HOLD_MAX) && (i_pc == RESET_HANDLER)) begin
                        r_state <= ST_RUN;
                        r_reset <= 1'b0;
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end
                end
            endcase
        end
    end

    assign o_reset      = r_reset;
    assign o_viol_cause = r_cause;
    assign o_viol_cnt   = r_cnt;

endmodule

// File: tb/tb_vrased_monitor.sv
// Directed bench for vrased_monitor; a second instance with a 2-bit counter shares the stimulus.
module tb_vrased_monitor;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;

    logic        reset_a;
    logic [6:0]  cause_a;
    logic [7:0]  cnt_a;
    logic        reset_b;
    logic [6:0]  cause_b;
    logic [1:0]  cnt_b;

    typedef struct {
        logic       r;
        logic [6:0] c;
        logic [7:0] n;
        logic [1:0] n2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    vrased_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .i_pc(pc), .i_data_en(data_en), .i_data_wr(data_wr),
        .i_data_addr(data_addr), .i_dma_en(dma_en), .i_dma_addr(dma_addr), .i_irq(irq),
        .o_reset(reset_a), .o_viol_cause(cause_a), .o_viol_cnt(cnt_a)
    );

    vrased_monitor #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .i_pc(pc), .i_data_en(data_en), .i_data_wr(data_wr),
        .i_data_addr(data_addr), .i_dma_en(dma_en), .i_dma_addr(dma_addr), .i_irq(irq),
        .o_reset(reset_b), .o_viol_cause(cause_b), .o_viol_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the outputs after the edge are compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("reset",      {7'd0, reset_a}, {7'd0, e.r});
                check("viol_cause", {1'b0, cause_a}, {1'b0, e.c});
                check("viol_cnt",   cnt_a,           e.n);
                check("reset_c2",   {7'd0, reset_b}, {7'd0, e.r});
                check("cause_c2",   {1'b0, cause_b}, {1'b0, e.c});
                check("cnt_c2",     {6'd0, cnt_b},   {6'd0, e.n2});
            end
        end
    end

    task automatic step(input logic rst, input logic [15:0] p, input logic de, input logic dw,
                        input logic [15:0] da, input logic dm, input logic [15:0] dma,
                        input logic iq, input logic er, input logic [6:0] ec, input int ecnt);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        pc        = p;
        data_en   = de;
        data_wr   = dw;
        data_addr = da;
        dma_en    = dm;
        dma_addr  = dma;
        irq       = iq;
        e.r  = er;
        e.c  = ec;
        e.n  = ecnt[7:0];
        e.n2 = (ecnt > 3) ? 2'd3 : ecnt[1:0];
        sb.push_back(e);
    endtask

    task automatic idle(input logic [15:0] p, input logic er, input logic [6:0] ec, input int ecnt);
        step(1'b1, p, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, er, ec, ecnt);
    endtask

    // Hold after a violation: pc parked on the reset handler, released on the fourth edge.
    task automatic release4(input logic [6:0] ec, input int ecnt);
        idle(16'h0000, 1'b1, ec, ecnt);
        idle(16'h0000, 1'b1, ec, ecnt);
        idle(16'h0000, 1'b1, ec, ecnt);
        idle(16'h0000, 1'b0, ec, ecnt);
    endtask

    initial begin
        rst_n = 1'b0; pc = 16'h0; data_en = 1'b0; data_wr = 1'b0;
        data_addr = 16'h0; dma_en = 1'b0; dma_addr = 16'h0; irq = 1'b0;

        // Reset state, then exactly four held cycles after release.
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 7'h00, 0);
        release4(7'h00, 0);
        idle(16'h0000, 1'b0, 7'h00, 0);

        // CPU read of the KEY region (region 2) from outside SMEM.
        step(1'b1, 16'h2000, 1'b1, 1'b0, 16'h6A10, 1'b0, 16'h0, 1'b0, 1'b1, 7'h40, 1);
        release4(7'h40, 1);

        // Entry into SMEM away from its base.
        idle(16'h2000, 1'b0, 7'h40, 1);
        idle(16'hA004, 1'b1, 7'h01, 2);
        release4(7'h01, 2);

        // Legal entry at base and legal exit from the last word, then an early exit.
        idle(16'h2000, 1'b0, 7'h01, 2);
        idle(16'hA000, 1'b0, 7'h01, 2);
        idle(16'hA002, 1'b0, 7'h01, 2);
        idle(16'hDFFE, 1'b0, 7'h01, 2);
        idle(16'h2000, 1'b0, 7'h01, 2);
        idle(16'hA000, 1'b0, 7'h01, 2);
        idle(16'hA100, 1'b0, 7'h01, 2);
        idle(16'h2000, 1'b1, 7'h02, 3);
        release4(7'h02, 3);

        // IRQ and DMA while in SMEM; DMA at 0x1000 is just past the XSTACK region.
        idle(16'h2000, 1'b0, 7'h02, 3);
        idle(16'hA000, 1'b0, 7'h02, 3);
        step(1'b1, 16'hA010, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000, 1'b1, 1'b1, 7'h0C, 4);
        // Violations during the hold are ignored.
        step(1'b1, 16'hA010, 1'b0, 1'b0, 16'h0, 1'b1, 16'h6A00, 1'b1, 1'b1, 7'h0C, 4);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 16'h6A10, 1'b0, 16'h0, 1'b0, 1'b1, 7'h0C, 4);
        idle(16'h0000, 1'b1, 7'h0C, 4);
        // Release beats a concurrent violation; the next RUN cycle's violation re-enters KILL.
        step(1'b1, 16'h0000, 1'b1, 1'b0, 16'h6A10, 1'b0, 16'h0, 1'b0, 1'b0, 7'h0C, 4);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 16'h6A10, 1'b0, 16'h0, 1'b0, 1'b1, 7'h40, 5);
        release4(7'h40, 5);

        // WPROT region 0: read ignored, write just past the end ignored, write inside flags.
        idle(16'h2000, 1'b0, 7'h40, 5);
        step(1'b1, 16'h2000, 1'b1, 1'b0, 16'h0240, 1'b0, 16'h0, 1'b0, 1'b0, 7'h40, 5);
        step(1'b1, 16'h2000, 1'b1, 1'b1, 16'h0250, 1'b0, 16'h0, 1'b0, 1'b0, 7'h40, 5);
        step(1'b1, 16'h2000, 1'b1, 1'b1, 16'h0240, 1'b0, 16'h0, 1'b0, 1'b1, 7'h10, 6);
        release4(7'h10, 6);

        // XSTACK: CPU access from inside SMEM is allowed, DMA to its last byte is not.
        idle(16'hA000, 1'b0, 7'h10, 6);
        step(1'b1, 16'hA002, 1'b1, 1'b0, 16'h0500, 1'b0, 16'h0, 1'b0, 1'b0, 7'h10, 6);
        step(1'b1, 16'hA004, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0FFF, 1'b0, 1'b1, 7'h28, 7);
        release4(7'h28, 7);

        // rst_n asserted mid-hold clears everything and restarts the hold.
        idle(16'h2000, 1'b0, 7'h28, 7);
        step(1'b1, 16'h2000, 1'b1, 1'b0, 16'h6A10, 1'b0, 16'h0, 1'b0, 1'b1, 7'h40, 8);
        idle(16'h0000, 1'b1, 7'h40, 8);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 7'h00, 0);
        release4(7'h00, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
